// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_FPU = 1;
    localparam int unsigned REQ_LSU = 2;
    localparam int unsigned REQ_DIV = 3;

    typedef struct packed {
        logic        gfflag;
        logic [3:0]  num;
        logic [31:0] data;
    } wb_req_t;

    // General registers occupy 0..15, float registers 16..31.
    function automatic logic [31:0] reg_onehot(input logic gfflag, input logic [3:0] num);
        logic [REG_IDX_W-1:0] idx;
        idx = {gfflag, num};
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the slot after `last`.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            grant_valid
);

    always_comb begin
        logic [IdxW-1:0] cand;
        cand        = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IdxW'((32'(last) + i) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant into a one-stage buffer feeding the
// register-file write port, plus a pending-register mask for decode stalls.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_gfflag,
    input  logic [N_REQ*4-1:0] req_num,
    input  logic [N_REQ*32-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               wr_enable,
    output logic               wr_gfflag,
    output logic [3:0]         wr_num,
    output logic [31:0]        wr_data,
    output logic [31:0]        pending
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    wb_req_t         req_s [N_REQ];
    logic [N_REQ-1:0] grant;
    logic [IdxW-1:0] grant_idx;
    logic            grant_valid;
    logic            accept;

    logic [IdxW-1:0] last_grant_d, last_grant_q;
    logic            wr_enable_d, wr_enable_q;
    wb_req_t         wr_req_d, wr_req_q;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_s[i].gfflag = req_gfflag[i];
            req_s[i].num    = req_num[i*4 +: 4];
            req_s[i].data   = req_data[i*32 +: 32];
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last        (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Nothing is accepted while in reset, so a grant in the reset cycle is dropped.
    always_comb begin
        accept    = grant_valid && !rst;
        req_ready = rst ? '0 : grant;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        wr_enable_d  = accept;
        wr_req_d     = wr_req_q;
        if (accept) begin
            last_grant_d = grant_idx;
            wr_req_d     = req_s[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IdxW'(N_REQ - 1);
            wr_enable_q  <= 1'b0;
            wr_req_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_enable_q  <= wr_enable_d;
            wr_req_q     <= wr_req_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                pending = pending | reg_onehot(req_s[i].gfflag, req_s[i].num);
            end
        end
        if (wr_enable_q && !rst) begin
            pending = pending | reg_onehot(wr_req_q.gfflag, wr_req_q.num);
        end
    end

    always_comb begin
        wr_enable = wr_enable_q;
        wr_gfflag = wr_req_q.gfflag;
        wr_num    = wr_req_q.num;
        wr_data   = wr_req_q.data;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the register file's single write port. Up to `N_REQ` execution units (ALU, FPU, LSU, divider) present write requests with a valid/ready handshake. The block grants one per cycle in round-robin order, registers the winner into a one-stage output buffer, and drives the register-file write port one cycle later. It also exports a 32-bit pending mask so decode can stall on registers with writes still in flight.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: request present, one bit per requester.
- `req_gfflag`  in  N_REQ: per requester, 0 = general register, 1 = float register.
- `req_num`  in  N_REQ×4: per-requester register number.
- `req_data`  in  N_REQ×32: per-requester write data.
- `req_ready`  out  N_REQ: one-hot grant; the request is accepted on a cycle with `valid && ready`.
- `wr_enable`  out  1: register-file write strobe.
- `wr_gfflag`  out  1: gfflag of the write.
- `wr_num`  out  4: register number of the write.
- `wr_data`  out  32: write data.
- `pending`  out  32: bit `{gfflag,num}` is set for every register targeted by a valid request or by the output stage.

## Operation
- Register index is `{gfflag, num}` (5 bits): general registers map to 0..15, float registers to 16..31.
- Arbitration:
  - Round-robin over `req_valid`, starting from the requester after `last_grant`.
  - At most one `req_ready` bit is high; it is high only where `req_valid` is high.
  - With no valid requests, `req_ready` is 0.
- `last_grant` (clog2(N_REQ) bits) updates only on an accepted request. Reset value is N_REQ-1, so requester 0 wins first.
- Output stage is always able to accept. No backpressure from the register file.
  - On accept: capture the winner's gfflag/num/data and set `wr_enable` = 1.
  - Otherwise `wr_enable` = 0 and the data fields hold their previous value.
- Requester rules:
  - A requester must hold valid and payload stable until accepted. Dropping valid early is illegal; the bench asserts it.
  - Payload changes while waiting are not checked. The value present in the accept cycle is the one written.
- No ordering between requesters. Two requests to the same register are written in grant order. Program order is the issuing unit's responsibility.
- `pending` is combinational: the OR of one-hot(`{gfflag,num}`) over all valid requests, plus the output stage when `wr_enable` = 1.

## Timing
- Latency: accept in cycle t leads to `wr_enable` = 1 in cycle t+1, with the payload captured at t.
- Throughput: one write per cycle.
- Fairness: a continuously valid requester is accepted within N_REQ cycles.
- `req_ready` is combinational from `req_valid` and `last_grant`. There is no combinational path from `req_data`.
- Reset values:
  - `wr_enable` = 0, `wr_gfflag` = 0, `wr_num` = 0, `wr_data` = 0, `last_grant` = N_REQ-1.
  - While `rst` is high, `req_ready` = 0.
  - `pending` reflects only `req_valid` while `rst` is high.
- Reset mid-operation: a request accepted in the cycle `rst` rises is discarded, and `wr_enable` is 0 on the next cycle. Requesters re-present after reset.
- Single requester valid: granted every cycle, back-to-back.
- `wr_enable` = 1 and a new request to the same register in the same cycle: both are reflected in `pending`, and both writes occur in sequence.

## Structure
- Shared package `wb_pkg`:
  - `wb_req_t` (gfflag, num[3:0], data[31:0]).
  - Requester index constants `REQ_ALU`=0, `REQ_FPU`=1, `REQ_LSU`=2, `REQ_DIV`=3.
  - `REG_IDX_W`=5.
- One sub-module, `rr_arbiter`:
  - Parameterised width; inputs `req`, `last`.
  - Output: one-hot `grant` plus encoded index.
  - Reused by other shared-resource controllers.

## Test plan
- Reset, then idle: `wr_enable` = 0, `pending` = 0, `req_ready` = 0 on all cycles.
- Only LSU valid with {1,4'h3,32'hDEADBEEF} for 3 cycles: `req_ready[2]` high each cycle; `wr_enable` = 1 on cycles 2–4 with `wr_gfflag` = 1, `wr_num` = 3, `wr_data` = DEADBEEF; `pending[19]` set throughout.
- All 4 valid continuously with distinct payloads: grant order 0,1,2,3,0,1…; each payload appears on the write port exactly one cycle after its grant.
- ALU and FPU both target general reg 5 (data 1 and 2): writes occur in grant order (1 then 2); `pending[5]` stays set until the second write cycle ends.
- `rst` asserted in a cycle where requester 1 is granted: no write on the following cycle; after release, requester 0 has priority again.
- Random valid patterns for 10k cycles with a scoreboard model: no lost or duplicated writes, and wait ≤ N_REQ cycles per request.
